sprite_plotter: RTL and testbench

SPRITE_PLOTTER -- requirements
Module: sprite_plotter

---
 rtl/sprite_plotter_pkg.sv | 28 ++
 rtl/sprite_scan_counter.sv | 51 +++++
 rtl/sprite_plotter.sv | 173 +++++++++++++++++
 tb/tb_sprite_plotter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_plotter_pkg.sv
// Shared definitions for the sprite plotter: screen geometry, named
// colours, the redraw FSM state type and an on-screen test helper.
package sprite_plotter_pkg;

    // Visible area of the VGA adapter in pixels.
    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    // Named colours (3-bit RGB).
    localparam logic [2:0] COL_BLACK = 3'b000;
    localparam logic [2:0] COL_WHITE = 3'b111;

    // Redraw sequencer states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ERASE = 2'd1,
        DRAW  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // True when a 9-bit coordinate pair lands inside the visible area.
    // Sums are kept 9 bits wide so that anything past the right or bottom
    // edge is rejected instead of wrapping back onto the screen.
    function automatic logic on_screen(input logic [8:0] x, input logic [8:0] y);
        return (x < 9'(SCREEN_W)) && (y < 9'(SCREEN_H));
    endfunction

endpackage

// File: rtl/sprite_scan_counter.sv
// Row-major scan counter over a SIZE x SIZE square. The column field
// advances every enabled cycle and wraps into the row field, so the scan
// starts at (0,0) and visits every pixel of a row before the next row.
// "last" flags the final pixel so the owner can leave its state.
module sprite_scan_counter
    import sprite_plotter_pkg::*;
#(
    parameter int SIZE = 4,
    localparam int HW  = (SIZE > 1) ? $clog2(SIZE) : 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          clear,
    input  logic          enable,
    output logic [HW-1:0] col,
    output logic [HW-1:0] row,
    output logic          last
);

    // Highest column / row index inside the square.
    localparam logic [HW-1:0] EDGE_MAX = HW'(SIZE - 1);

    // Clear wins over enable so a state can restart the scan on the same
    // edge it finishes the previous one.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            col <= '0;
            row <= '0;
        end else if (clear) begin
            col <= '0;
            row <= '0;
        end else if (enable) begin
            if (col == EDGE_MAX) begin
                col <= '0;
                if (row == EDGE_MAX) begin
                    row <= '0;
                end else begin
                    row <= row + 1'b1;
                end
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // Final pixel of the square is bottom-right.
    always_comb begin
        last = (col == EDGE_MAX) && (row == EDGE_MAX);
    end

endmodule

// File: rtl/sprite_plotter.sv
// Sprite plotter: on each accepted frame tick, erases the sprite at its
// previous position (only if it moved) and draws it at the new position,
// one pixel per cycle, into a VGA adapter's pixel-write port.
//
// Handshake: frame_tick is a fire-and-forget request accepted only while
// busy is low; ticks that arrive while busy is high are dropped, not
// queued. plot is a write strobe: vga_x/vga_y/vga_colour are a valid pixel
// in exactly the cycles plot is high, and hold their last values otherwise.
// done pulses for one cycle as the redraw finishes, in the same cycle busy
// falls.
module sprite_plotter
    import sprite_plotter_pkg::*;
#(
    parameter int         SIZE         = 4,
    parameter logic [2:0] ERASE_COLOUR = 3'b000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       frame_tick,
    input  logic [7:0] obj_x,
    input  logic [6:0] obj_y,
    input  logic [2:0] obj_colour,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       plot,
    output logic       busy,
    output logic       done,
    output logic [1:0] fsm_state
);

    localparam int HW = (SIZE > 1) ? $clog2(SIZE) : 1;

    state_t          state;

    // Position/colour being drawn this redraw, and where the sprite was
    // left by the last completed redraw.
    logic [7:0]      new_x;
    logic [6:0]      new_y;
    logic [2:0]      new_col;
    logic [7:0]      prev_x;
    logic [6:0]      prev_y;
    logic            prev_valid;

    logic            scan_clear;
    logic            scan_enable;
    logic [HW-1:0]   scan_col;
    logic [HW-1:0]   scan_row;
    logic            scan_last;

    logic            moved;
    logic [7:0]      base_x;
    logic [6:0]      base_y;
    logic [8:0]      sum_x;
    logic [8:0]      sum_y;
    logic [2:0]      pix_colour;
    logic            visible;

    assign fsm_state = state;

    sprite_scan_counter #(
        .SIZE (SIZE)
    ) u_scan (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (scan_clear),
        .enable  (scan_enable),
        .col     (scan_col),
        .row     (scan_row),
        .last    (scan_last)
    );

    // Scan control: restart on an accepted tick and again when ERASE hands
    // over to DRAW; step once per cycle while emitting pixels.
    always_comb begin
        scan_clear  = 1'b0;
        scan_enable = 1'b0;
        case (state)
            IDLE:    scan_clear  = frame_tick;
            ERASE: begin
                scan_enable = 1'b1;
                scan_clear  = scan_last;
            end
            DRAW:    scan_enable = 1'b1;
            default: ;
        endcase
    end

    // An erase is only worth doing when a previous image exists and the
    // sprite's top-left corner actually moved; a colour-only change is
    // fully covered by the redraw.
    always_comb begin
        moved = prev_valid && ((obj_x != prev_x) || (obj_y != prev_y));
    end

    // Current pixel: origin and colour come from the old image in ERASE and
    // the new one in DRAW; sums are 9 bits so clipping never wraps.
    always_comb begin
        if (state == ERASE) begin
            base_x     = prev_x;
            base_y     = prev_y;
            pix_colour = ERASE_COLOUR;
        end else begin
            base_x     = new_x;
            base_y     = new_y;
            pix_colour = new_col;
        end
        sum_x   = {1'b0, base_x} + 9'(scan_col);
        sum_y   = {2'b00, base_y} + 9'(scan_row);
        visible = on_screen(sum_x, sum_y);
    end

    // Redraw sequencer with registered pixel-port and status outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            plot       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
            new_x      <= '0;
            new_y      <= '0;
            new_col    <= '0;
            prev_x     <= '0;
            prev_y     <= '0;
            prev_valid <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    plot <= 1'b0;
                    if (frame_tick) begin
                        new_x   <= obj_x;
                        new_y   <= obj_y;
                        new_col <= obj_colour;
                        busy    <= 1'b1;
                        state   <= moved ? ERASE : DRAW;
                    end
                end
                ERASE, DRAW: begin
                    // Off-screen pixels still use their cycle but never
                    // strobe plot, and the port keeps its last values.
                    plot <= visible;
                    if (visible) begin
                        vga_x      <= sum_x[7:0];
                        vga_y      <= sum_y[6:0];
                        vga_colour <= pix_colour;
                    end
                    if (scan_last) begin
                        state <= (state == ERASE) ? DRAW : DONE;
                    end
                end
                DONE: begin
                    plot       <= 1'b0;
                    done       <= 1'b1;
                    busy       <= 1'b0;
                    prev_x     <= new_x;
                    prev_y     <= new_y;
                    prev_valid <= 1'b1;
                    state      <= IDLE;
                end
                default: begin
                    plot  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_plotter.sv
// Self-checking bench for sprite_plotter. A reference model builds, from
// the plotting rules, the ordered list of pixels each redraw must produce
// and the cycle on which done must pulse; every plot is checked against it.
module tb_sprite_plotter;
    import sprite_plotter_pkg::*;

    localparam int         SIZE      = 4;
    localparam logic [2:0] ERASE_COL = 3'b000;

    logic       clk;
    logic       reset_n;
    logic       frame_tick;
    logic [7:0] obj_x;
    logic [6:0] obj_y;
    logic [2:0] obj_colour;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       plot;
    logic       busy;
    logic       done;
    logic [1:0] fsm_state;

    int tests;
    int fails;

    // Reference model state: where the sprite image currently is.
    bit         m_prev_valid;
    logic [7:0] m_prev_x;
    logic [6:0] m_prev_y;
    logic [17:0] exp_q[$];
    logic [17:0] last_pix;

    sprite_plotter #(
        .SIZE         (SIZE),
        .ERASE_COLOUR (ERASE_COL)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .frame_tick (frame_tick),
        .obj_x      (obj_x),
        .obj_y      (obj_y),
        .obj_colour (obj_colour),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .plot       (plot),
        .busy       (busy),
        .done       (done),
        .fsm_state  (fsm_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add_square(input int x, input int y, input logic [2:0] c);
        for (int r = 0; r < SIZE; r++) begin
            for (int k = 0; k < SIZE; k++) begin
                if ((x + k) < 160 && (y + r) < 120)
                    exp_q.push_back({8'(x + k), 7'(y + r), c});
            end
        end
    endtask

    // Builds the expected pixel stream and returns the number of pixel cycles.
    task automatic model_frame(input logic [7:0] x, input logic [6:0] y,
                               input logic [2:0] c, output int cycles);
        bit erase;
        erase = m_prev_valid && (x != m_prev_x || y != m_prev_y);
        exp_q.delete();
        if (erase) add_square(int'(m_prev_x), int'(m_prev_y), ERASE_COL);
        add_square(int'(x), int'(y), c);
        cycles = (erase ? 2 : 1) * SIZE * SIZE;
        m_prev_valid = 1'b1;
        m_prev_x = x;
        m_prev_y = y;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        frame_tick = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        m_prev_valid = 1'b0;
        m_prev_x = '0;
        m_prev_y = '0;
        last_pix = '0;
        exp_q.delete();
    endtask

    // Per-cycle check of the pixel port against the expected stream.
    task automatic check_pixel(input string name);
        logic [17:0] e;
        tests++;
        if (plot === 1'b1) begin
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL %s: unexpected plot x=%0d y=%0d c=%0d, none required",
                         name, vga_x, vga_y, vga_colour);
            end else begin
                e = exp_q.pop_front();
                if ({vga_x, vga_y, vga_colour} !== e) begin
                    fails++;
                    $display("FAIL %s: pixel x=%0d y=%0d c=%0d, required x=%0d y=%0d c=%0d",
                             name, vga_x, vga_y, vga_colour, e[17:10], e[9:3], e[2:0]);
                end
            end
            last_pix = {vga_x, vga_y, vga_colour};
        end else if ({vga_x, vga_y, vga_colour} !== last_pix) begin
            fails++;
            $display("FAIL %s: port moved while plot=0: %h, required hold %h",
                     name, {vga_x, vga_y, vga_colour}, last_pix);
        end
    endtask

    // One redraw; extra ticks are pulsed at cycles t1/t2 after the accepted
    // tick (0 = none), and obj_* are scrambled throughout the redraw.
    task automatic run_frame(input string name, input logic [7:0] x, input logic [6:0] y,
                             input logic [2:0] c, input int t1, input int t2);
        int n;
        int done_at;
        int dones;
        model_frame(x, y, c, n);
        done_at = n + 1;
        dones = 0;
        obj_x = x;
        obj_y = y;
        obj_colour = c;
        frame_tick = 1'b1;
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
        for (int cyc = 1; cyc <= done_at + 2; cyc++) begin
            @(posedge clk);
            #1;
            obj_x = 8'($urandom_range(0, 159));
            obj_y = 7'($urandom_range(0, 119));
            obj_colour = 3'($urandom_range(0, 7));
            frame_tick = (cyc == t1 || cyc == t2);
            check_pixel(name);
            if (done === 1'b1) dones++;
            tests++;
            if (cyc < done_at && busy !== 1'b1) begin
                fails++;
                $display("FAIL %s busy: cycle %0d busy=%b, required 1", name, cyc, busy);
            end else if (cyc >= done_at && busy !== 1'b0) begin
                fails++;
                $display("FAIL %s busy: cycle %0d busy=%b, required 0", name, cyc, busy);
            end
            tests++;
            if (done !== (cyc == done_at)) begin
                fails++;
                $display("FAIL %s done: cycle %0d done=%b, required %0b",
                         name, cyc, done, (cyc == done_at));
            end
        end
        frame_tick = 1'b0;
        tests++;
        if (dones != 1 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL %s completion: %0d done pulses and %0d pixels missing, required 1 and 0",
                     name, dones, exp_q.size());
        end
    endtask

    task automatic test_reset();
        apply_reset();
        tests++;
        if ({plot, busy, done} !== 3'b000 || {vga_x, vga_y, vga_colour} !== 18'd0 ||
            fsm_state !== IDLE) begin
            fails++;
            $display("FAIL reset: plot=%b busy=%b done=%b pix=%h state=%0d, required all zero",
                     plot, busy, done, {vga_x, vga_y, vga_colour}, fsm_state);
        end
    endtask

    task automatic test_first_draw();
        run_frame("first_draw", 8'd78, 7'd100, COL_WHITE, 0, 0);
    endtask

    task automatic test_move_erase();
        run_frame("move_erase", 8'd79, 7'd100, COL_WHITE, 0, 0);
    endtask

    task automatic test_busy_ticks();
        run_frame("busy_ticks", 8'd81, 7'd102, COL_WHITE, 5, 20);
    endtask

    task automatic test_colour_only();
        run_frame("colour_only", 8'd81, 7'd102, COL_BLACK, 0, 0);
    endtask

    task automatic test_clip();
        apply_reset();
        run_frame("clip_draw", 8'd158, 7'd118, COL_WHITE, 0, 0);
        run_frame("clip_erase", 8'd10, 7'd5, 3'b010, 0, 0);
    endtask

    task automatic test_reset_mid_draw();
        int n;
        run_frame("pre_abort", 8'd20, 7'd30, 3'b101, 0, 0);
        model_frame(8'd20, 7'd30, 3'b010, n);
        obj_x = 8'd20;
        obj_y = 7'd30;
        obj_colour = 3'b010;
        frame_tick = 1'b1;
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(posedge clk);
            #1;
            check_pixel("abort_draw");
        end
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        tests++;
        if (plot !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || fsm_state !== IDLE) begin
            fails++;
            $display("FAIL abort: plot=%b busy=%b done=%b state=%0d, required 0 0 0 IDLE",
                     plot, busy, done, fsm_state);
        end
        reset_n = 1'b1;
        m_prev_valid = 1'b0;
        last_pix = '0;
        exp_q.delete();
        @(posedge clk);
        #1;
        check_pixel("after_abort");
        run_frame("post_abort_no_erase", 8'd60, 7'd40, 3'b011, 0, 0);
    endtask

    task automatic test_random();
        logic [7:0] x;
        logic [6:0] y;
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 3) == 0 && m_prev_valid) begin
                x = m_prev_x;
                y = m_prev_y;
            end else if ($urandom_range(0, 2) == 0) begin
                x = 8'($urandom_range(154, 159));
                y = 7'($urandom_range(114, 119));
            end else begin
                x = 8'($urandom_range(0, 159));
                y = 7'($urandom_range(0, 119));
            end
            run_frame("random", x, y, 3'($urandom_range(0, 7)), 0,
                      ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 14)) : 0);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        frame_tick = 1'b0;
        obj_x = '0;
        obj_y = '0;
        obj_colour = '0;
        reset_n = 1'b0;
        last_pix = '0;
        test_reset();
        test_first_draw();
        test_move_erase();
        test_busy_ticks();
        test_colour_only();
        test_clip();
        test_reset_mid_draw();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
